jk_sync_counter: RTL and testbench
==================================

// Module: jk_sync_counter
// PURPOSE
//  Synchronous N-bit up/down counter built from clocked JK storage cells, with
//  per-bit J/K steering logic feeding each cell. Sits directly upstream of the
//  JK storage element: generates the J/K drive each bit needs (hold/set/reset/
//  toggle) and owns the clocking and reset that the bare latch lacks.
//  Used as the sequential stimulus and count source for the JK cell library.
// PARAMETERS
//  WIDTH    4     counter width in bits (>=1)
//  RST_VAL  0     value loaded into q on reset (WIDTH bits)
// PORTS
//  clk    in   1      single clock, all state updates on posedge
//  rst    in   1      synchronous reset, active-high
//  en     in   1      count enable
//  up_dn  in   1      1 = count up, 0 = count down
//  load   in   1      parallel load strobe
//  d      in   WIDTH  parallel load value
//  q      out  WIDTH  counter value (registered, JK cell outputs)
//  qbar   out  WIDTH  bitwise complement of q (cell qbar outputs)
//  tc     out  1      terminal count (combinational)
// BEHAVIOUR
//  - Priority per posedge clk: rst > load > en > hold.
//  - rst=1: q <= RST_VAL, qbar <= ~RST_VAL next edge; rst mid-count abandons count.
//  - load=1: cell i gets J=d[i], K=~d[i]; q <= d next edge; en/up_dn ignored.
//  - en=1, load=0: toggle chain T[0]=1, T[i]=T[i-1] & (up_dn ? q[i-1] : ~q[i-1]);
//    cell i gets J=K=T[i]; q <= q+1 (up) or q-1 (down) mod 2^WIDTH, 1-cycle latency.
//  - en=0, load=0: all cells J=K=0 (hold); q unchanged.
//  - J=1,K=1 is legal only as toggle; steering never drives J=1,K=1 during load.
//  - tc = en & (up_dn ? (q == all ones) : (q == 0)); independent of load.
//    After reset with RST_VAL=0: tc = en & ~up_dn.
//  - up_dn may change any cycle; sampled on the same edge as en.
//  - qbar == ~q at all times after first clock edge with rst=1.
// CONFIGURATION
//  - Macro JK_CNT_SAT_EN.
//    Defined: saturating. At all-ones counting up, or zero counting down, all
//    cells forced J=K=0; q holds, tc stays 1 while en and direction persist.
//    Load and reset unaffected.
//    Undefined: wrapping. all-ones+1 -> 0, 0-1 -> all-ones; tc high one cycle
//    per wrap while en=1.
// STRUCTURE
//  - Package jk_pkg: 2-bit {J,K} mode constants JK_HOLD=2'b00, JK_RST=2'b01,
//    JK_SET=2'b10, JK_TGL=2'b11; shared by cell and steering logic.
//  - Sub-module jk_ff_cell: one clocked JK flip-flop, sync active-high rst,
//    parameter RST_BIT; ports clk, rst, j, k, q, qbar. Instantiated WIDTH times
//    via generate; q/qbar of cell i drive q[i]/qbar[i].
//  - Top level holds only the toggle chain, load/hold muxing, saturation gate
//    and tc compare.
// TESTING (WIDTH=4, RST_VAL=0 unless noted)
//  - rst=1 two cycles, en=1 up_dn=1 -> q=0000, qbar=1111; release, 3 edges -> q=0011.
//  - Count up from 1110, en=1: q=1111 with tc=1; next edge q=0000 (wrap build)
//    or q=1111 held, tc=1 (JK_CNT_SAT_EN build).
//  - From 0000 en=1 up_dn=0 -> tc=1; next edge q=1111 (wrap) / q=0000 held (sat).
//  - load=1 d=1010 with en=1 up_dn=1 -> q=1010 next edge (load wins); then en=0
//    four cycles -> q stays 1010, qbar=0101.
//  - Counting at q=0110, assert rst one cycle with load=1 d=1111 -> q=0000.
//  - RST_VAL=4'b1001 instance: rst -> q=1001; toggle up_dn each cycle with en=1
//    -> q alternates 1010, 1001, 1010.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared {J,K} drive encodings for the JK cell and the counter steering logic.
package jk_pkg;

    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t JK_HOLD = 2'b00;
    localparam jk_mode_t JK_RST  = 2'b01;
    localparam jk_mode_t JK_SET  = 2'b10;
    localparam jk_mode_t JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// Single clocked JK flip-flop with synchronous active-high reset to RST_BIT.
module jk_ff_cell
    import jk_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RST_BIT;
        end else begin
            case ({j, k})
                JK_RST:  q_reg <= 1'b0;
                JK_SET:  q_reg <= 1'b1;
                JK_TGL:  q_reg <= ~q_reg;
                default: q_reg <= q_reg;
            endcase
        end
    end

    assign q    = q_reg;
    assign qbar = ~q_reg;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter built from JK cells with per-bit J/K steering.
// Define JK_CNT_SAT_EN for a saturating counter; otherwise it wraps.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    logic [WIDTH-1:0] tgl;
    logic             at_limit;
    logic             count_ok;
    jk_mode_t         mode [WIDTH];

    assign at_limit = up_dn ? (&q) : ~(|q);
    assign tc       = en & at_limit;

`ifdef JK_CNT_SAT_EN
    // At the terminal value every cell is held so the count sticks there.
    assign count_ok = en & ~at_limit;
`else
    assign count_ok = en;
`endif

    // Ripple toggle chain: bit i flips when all lower bits are at their carry/borrow value.
    assign tgl[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign tgl[gi] = tgl[gi-1] & (up_dn ? q[gi-1] : ~q[gi-1]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                mode[gi] = JK_HOLD;
                if (load) begin
                    mode[gi] = d[gi] ? JK_SET : JK_RST;
                end else if (count_ok && tgl[gi]) begin
                    mode[gi] = JK_TGL;
                end
            end

            jk_ff_cell #(
                .RST_BIT (RST_VAL[gi])
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .j    (mode[gi][1]),
                .k    (mode[gi][0]),
                .q    (q[gi]),
                .qbar (qbar[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter: a default instance and one with RST_VAL=4'b1001.
module tb_jk_sync_counter;

`ifdef JK_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       a_rst, a_en, a_up_dn, a_load;
    logic [3:0] a_d, a_q, a_qbar;
    logic       a_tc;
    logic       b_rst, b_en, b_up_dn, b_load;
    logic [3:0] b_d, b_q, b_qbar;
    logic       b_tc;

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(4), .RST_VAL(4'b0000)) u_dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up_dn), .load(a_load),
        .d(a_d), .q(a_q), .qbar(a_qbar), .tc(a_tc)
    );

    jk_sync_counter #(.WIDTH(4), .RST_VAL(4'b1001)) u_dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up_dn), .load(b_load),
        .d(b_d), .q(b_q), .qbar(b_qbar), .tc(b_tc)
    );

    typedef struct {
        int         sel;
        logic [3:0] q;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] model_a, model_b;
    bit         valid_a = 1'b0;
    bit         valid_b = 1'b0;

    // One clock of stimulus on instance sel; the other instance is held idle.
    task automatic cycle(input int sel, input logic r, input logic l, input logic e,
                         input logic u, input logic [3:0] dv, input string name);
        logic [3:0] cur, rv, nq, obs_q, obs_qb;
        logic       exp_tc, obs_tc, limit;
        bit         valid;
        exp_t       ex;
        cur   = (sel == 0) ? model_a : model_b;
        rv    = (sel == 0) ? 4'b0000 : 4'b1001;
        valid = (sel == 0) ? valid_a : valid_b;
        if (sel == 0) begin
            a_rst = r; a_load = l; a_en = e; a_up_dn = u; a_d = dv;
            b_rst = 1'b0; b_load = 1'b0; b_en = 1'b0; b_up_dn = 1'b0; b_d = 4'h0;
        end else begin
            b_rst = r; b_load = l; b_en = e; b_up_dn = u; b_d = dv;
            a_rst = 1'b0; a_load = 1'b0; a_en = 1'b0; a_up_dn = 1'b0; a_d = 4'h0;
        end
        #1;
        limit = u ? (cur == 4'hF) : (cur == 4'h0);
        if (valid) begin
            exp_tc = e & limit;
            obs_tc = (sel == 0) ? a_tc : b_tc;
            vectors++;
            if (obs_tc !== exp_tc) begin
                miscompares++;
                $display("FAIL %s tc inst%0d: got %b expected %b (q model %b)", name, sel, obs_tc, exp_tc, cur);
            end
        end
        if (r)                 nq = rv;
        else if (l)            nq = dv;
        else if (e && SAT && limit) nq = cur;
        else if (e)            nq = u ? cur + 4'd1 : cur - 4'd1;
        else                   nq = cur;
        sb.push_back('{sel, nq, name});
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        obs_q  = (ex.sel == 0) ? a_q : b_q;
        obs_qb = (ex.sel == 0) ? a_qbar : b_qbar;
        if (r || valid) begin
            vectors++;
            if (obs_q !== ex.q || obs_qb !== ~ex.q) begin
                miscompares++;
                $display("FAIL %s q/qbar inst%0d: got %b/%b expected %b/%b", ex.name, ex.sel, obs_q, obs_qb, ex.q, ~ex.q);
            end else begin
                $display("ok   %s inst%0d rst=%b load=%b en=%b up=%b d=%b -> q=%b", ex.name, ex.sel, r, l, e, u, dv, obs_q);
            end
            if (sel == 0) begin model_a = nq; valid_a = 1'b1; end
            else          begin model_b = nq; valid_b = 1'b1; end
        end
    endtask

    task automatic test_reset();
        cycle(0, 1, 0, 1, 1, 4'h0, "reset1");
        cycle(0, 1, 0, 1, 1, 4'h0, "reset2");
        cycle(0, 0, 0, 1, 1, 4'h0, "count_up1");
        cycle(0, 0, 0, 1, 1, 4'h0, "count_up2");
        cycle(0, 0, 0, 1, 1, 4'h0, "count_up3");
        if (a_q !== 4'b0011) begin
            miscompares++;
            $display("FAIL post_reset_count: got %b expected 0011", a_q);
        end
        vectors++;
    endtask

    task automatic test_wrap_up();
        cycle(0, 0, 1, 0, 1, 4'b1110, "load_1110");
        cycle(0, 0, 0, 1, 1, 4'h0, "up_to_1111");
        cycle(0, 0, 0, 1, 1, 4'h0, "up_wrap");
        cycle(0, 0, 0, 1, 1, 4'h0, "up_after_wrap");
    endtask

    task automatic test_wrap_down();
        cycle(0, 0, 1, 0, 0, 4'b0000, "load_0000");
        cycle(0, 0, 0, 1, 0, 4'h0, "down_wrap");
        cycle(0, 0, 0, 1, 0, 4'h0, "down_after_wrap");
    endtask

    task automatic test_load_priority();
        cycle(0, 0, 1, 1, 1, 4'b1010, "load_over_en");
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 4'h5, "hold");
    endtask

    task automatic test_reset_priority();
        cycle(0, 0, 1, 0, 1, 4'b0101, "load_0101");
        cycle(0, 0, 0, 1, 1, 4'h0, "up_to_0110");
        cycle(0, 1, 1, 1, 1, 4'b1111, "rst_over_load");
    endtask

    task automatic test_rst_val();
        cycle(1, 1, 0, 0, 0, 4'h0, "rstval_reset");
        cycle(1, 0, 0, 1, 1, 4'h0, "rstval_up");
        cycle(1, 0, 0, 1, 0, 4'h0, "rstval_down");
        cycle(1, 0, 0, 1, 1, 4'h0, "rstval_up2");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            cycle(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        a_rst = 1'b0; a_en = 1'b0; a_up_dn = 1'b0; a_load = 1'b0; a_d = 4'h0;
        b_rst = 1'b0; b_en = 1'b0; b_up_dn = 1'b0; b_load = 1'b0; b_d = 4'h0;
        model_a = 4'h0;
        model_b = 4'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_reset_priority();
        test_rst_val();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
